// File: rtl/keylock_pkg.sv
// Shared keypad definitions for the keylock code path: command key values,
// digit width and the command-key classifier.
package keylock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] KEY_PRINT = 4'd7;
  localparam logic [DIGIT_W-1:0] KEY_REPRO = 4'd8;
  localparam logic [DIGIT_W-1:0] KEY_LOCK  = 4'd9;

  // Command keys end an entry; every other key value is a digit.
  function automatic logic is_cmd_key(input logic [DIGIT_W-1:0] key);
    return (key == KEY_PRINT) || (key == KEY_REPRO) || (key == KEY_LOCK);
  endfunction

endpackage

// File: rtl/code_shift_buf.sv
// Entry buffer: shifts digits in from the right, keeps only the newest
// CODE_LEN digits and counts how many are held (saturating at CODE_LEN).
module code_shift_buf
  import keylock_pkg::*;
#(
  parameter int CODE_LEN = 4
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              clear,
  input  logic                              shift,
  input  logic [DIGIT_W-1:0]                din,
  output logic [CODE_LEN*DIGIT_W-1:0]       entry,
  output logic [$clog2(CODE_LEN+1)-1:0]     count,
  output logic                              full
);

  localparam int W  = CODE_LEN * DIGIT_W;
  localparam int CW = $clog2(CODE_LEN + 1);

  logic [W-1:0]  entry_reg;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  shifted;

  // Digit 0 takes the new key; every other digit takes its lower neighbour,
  // so the oldest digit falls off the top.
  genvar gi;
  generate
    for (gi = 0; gi < CODE_LEN; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign shifted[DIGIT_W-1:0] = din;
      end else begin : g_upper
        assign shifted[gi*DIGIT_W +: DIGIT_W] = entry_reg[(gi-1)*DIGIT_W +: DIGIT_W];
      end
    end
  endgenerate

  // Entry/count update: reset beats clear, clear beats shift.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      entry_reg <= '0;
      count_reg <= '0;
    end else if (clear) begin
      entry_reg <= '0;
      count_reg <= '0;
    end else if (shift) begin
      entry_reg <= shifted;
      if (count_reg != CW'(CODE_LEN)) begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign entry = entry_reg;
  assign count = count_reg;
  assign full  = (count_reg == CW'(CODE_LEN));

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad code sequencer between the keypad decoder and the lock FSM.
// Buffers digits, holds program/user/candidate codes, produces match and
// ValidUC combinationally for the FSM, and commits codes on FSM strobes.
module code_entry_ctrl
  import keylock_pkg::*;
#(
  parameter int                           CODE_LEN   = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_PC = 16'h1234
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            rdy,
  input  logic [DIGIT_W-1:0]              keypress,
  input  logic                            CheckPC,
  input  logic                            CheckValidUC,
  input  logic                            confirmUC,
  input  logic                            LOCKING,
  input  logic                            ToggleLED1,
  input  logic                            Chillin,
  input  logic                            error,
  output logic                            match,
  output logic                            ValidUC,
  output logic                            locked,
  output logic [$clog2(CODE_LEN+1)-1:0]   digitCount
);

  localparam int W = CODE_LEN * DIGIT_W;

  logic         mode_any;
  logic         cmd_key;
  logic         cmd_strobe;
  logic         buf_clear;
  logic         buf_shift;
  logic [W-1:0] entry;
  logic         full;

  logic [W-1:0] last_entry_reg;
  logic [W-1:0] cand_reg;
  logic [W-1:0] uc_reg;
  logic [W-1:0] pc_reg;
  logic         locked_reg;
  logic         chillin_d_reg;

  assign mode_any   = CheckPC | CheckValidUC | confirmUC | LOCKING;
  assign cmd_key    = is_cmd_key(keypress);
  // A command key only counts while the FSM is in some entry mode.
  assign cmd_strobe = rdy & cmd_key & mode_any;
  assign buf_clear  = ~mode_any | error | cmd_strobe;
  assign buf_shift  = rdy & ~cmd_key;

  code_shift_buf #(
    .CODE_LEN (CODE_LEN)
  ) u_buf (
    .clk    (clk),
    .resetN (resetN),
    .clear  (buf_clear),
    .shift  (buf_shift),
    .din    (keypress),
    .entry  (entry),
    .count  (digitCount),
    .full   (full)
  );

  // Comparison result for the current FSM mode, in priority order.
  always_comb begin
    match = 1'b0;
    if (full) begin
      if (CheckPC) begin
        match = (entry == pc_reg);
      end else if (confirmUC) begin
        match = (entry == cand_reg);
      end else if (LOCKING && locked_reg) begin
        match = (entry == uc_reg);
      end else if (LOCKING) begin
        match = 1'b1;
      end
    end
  end

  // A new code must be complete and differ from the program code.
  assign ValidUC = CheckValidUC & full & (entry != pc_reg);

  // Code registers and commits; commits read only registered codes so a
  // digit arriving in the same cycle cannot disturb them.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      last_entry_reg <= '0;
      cand_reg       <= '0;
      uc_reg         <= '0;
      pc_reg         <= DEFAULT_PC;
      locked_reg     <= 1'b0;
      chillin_d_reg  <= 1'b0;
    end else begin
      chillin_d_reg <= Chillin;
      if (cmd_strobe) begin
        last_entry_reg <= entry;
      end
      if (rdy && (keypress == KEY_REPRO) && ValidUC) begin
        cand_reg <= entry;
      end
      if (ToggleLED1) begin
        if (!locked_reg) begin
          uc_reg     <= last_entry_reg;
          locked_reg <= 1'b1;
        end else begin
          locked_reg <= 1'b0;
        end
      end
      if (Chillin && !chillin_d_reg) begin
        pc_reg <= cand_reg;
      end
    end
  end

  assign locked = locked_reg;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl. Stimulus pushes expected outputs into
// a scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_code_entry_ctrl;

  logic       clk;
  logic       resetN;
  logic       rdy;
  logic [3:0] keypress;
  logic       CheckPC, CheckValidUC, confirmUC, LOCKING;
  logic       ToggleLED1, Chillin, error;
  logic       match, ValidUC, locked;
  logic [2:0] digitCount;

  code_entry_ctrl #(
    .CODE_LEN   (4),
    .DEFAULT_PC (16'h1234)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .rdy          (rdy),
    .keypress     (keypress),
    .CheckPC      (CheckPC),
    .CheckValidUC (CheckValidUC),
    .confirmUC    (confirmUC),
    .LOCKING      (LOCKING),
    .ToggleLED1   (ToggleLED1),
    .Chillin      (Chillin),
    .error        (error),
    .match        (match),
    .ValidUC      (ValidUC),
    .locked       (locked),
    .digitCount   (digitCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sel: 0 match, 1 ValidUC, 2 locked, 3 digitCount
  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   act;
      e = sb.pop_front();
      case (e.sel)
        0:       act = int'(match);
        1:       act = int'(ValidUC);
        2:       act = int'(locked);
        default: act = int'(digitCount);
      endcase
      vectors++;
      if (act != e.val) begin
        miscompares++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, act, e.val, $time);
      end else begin
        $display("ok   %s = %0d", e.name, act);
      end
    end
  end

  task automatic expect_out(input string name, input int sel, input int val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [3:0] k);
    rdy = 1'b1;
    keypress = k;
    tick();
    rdy = 1'b0;
  endtask

  task automatic digits4(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) begin
      digit(code[i*4 +: 4]);
    end
  endtask

  // Command key with an expectation checked in the same cycle.
  task automatic cmd(input logic [3:0] k, input string name, input int sel, input int val);
    rdy = 1'b1;
    keypress = k;
    expect_out(name, sel, val);
    tick();
    rdy = 1'b0;
  endtask

  task automatic toggle();
    ToggleLED1 = 1'b1;
    tick();
    ToggleLED1 = 1'b0;
  endtask

  task automatic modes_off();
    CheckPC = 1'b0; CheckValidUC = 1'b0; confirmUC = 1'b0; LOCKING = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; rdy = 1'b0; keypress = 4'd0;
    modes_off();
    ToggleLED1 = 1'b0; Chillin = 1'b0; error = 1'b0;
    repeat (2) tick();
    resetN = 1'b1;
    expect_out("reset_locked", 2, 0);
    expect_out("reset_count", 3, 0);
    expect_out("reset_match", 0, 0);
    tick();

    // 1. Lock with 5031: any full code locks while unlocked.
    LOCKING = 1'b1;
    digits4(16'h5031);
    expect_out("lock_count_full", 3, 4);
    cmd(4'd9, "lock_match", 0, 1);
    LOCKING = 1'b0;
    expect_out("lock_count_cleared", 3, 0);
    toggle();
    expect_out("lock_locked", 2, 1);
    tick();

    // 2. Wrong unlock, then error clears a partial entry.
    LOCKING = 1'b1;
    digits4(16'h5032);
    cmd(4'd9, "wrong_unlock_match", 0, 0);
    digit(4'd5);
    expect_out("pre_error_count", 3, 1);
    error = 1'b1;
    tick();
    expect_out("error_count", 3, 0);
    expect_out("error_still_locked", 2, 1);
    error = 1'b0;
    tick();

    // Correct unlock proves uc was committed as 5031.
    digits4(16'h5031);
    cmd(4'd9, "right_unlock_match", 0, 1);
    LOCKING = 1'b0;
    toggle();
    expect_out("unlocked", 2, 0);
    tick();

    // 3. Short code never matches.
    LOCKING = 1'b1;
    digit(4'd4); digit(4'd4); digit(4'd4);
    expect_out("short_count", 3, 3);
    cmd(4'd9, "short_match", 0, 0);
    LOCKING = 1'b0;
    tick();

    // 4. Reprogram PC to 6601.
    CheckPC = 1'b1;
    digits4(16'h1234);
    cmd(4'd8, "checkpc_default", 0, 1);
    CheckPC = 1'b0; CheckValidUC = 1'b1;
    digits4(16'h1234);
    cmd(4'd8, "validuc_same_as_pc", 1, 0);
    digit(4'd6); digit(4'd6); digit(4'd0);
    expect_out("validuc_not_full", 1, 0);
    digit(4'd1);
    cmd(4'd8, "validuc_new", 1, 1);
    CheckValidUC = 1'b0; confirmUC = 1'b1;
    digits4(16'h6601);
    cmd(4'd8, "confirm_match", 0, 1);
    confirmUC = 1'b0; Chillin = 1'b1;
    tick(); tick();
    Chillin = 1'b0;
    CheckPC = 1'b1;
    digits4(16'h1234);
    cmd(4'd8, "old_pc_rejected", 0, 0);
    digits4(16'h6601);
    cmd(4'd8, "new_pc_match", 0, 1);

    // 5. Overflow keeps the newest four digits.
    digit(4'd1); digits4(16'h2345);
    expect_out("overflow_count", 3, 4);
    expect_out("overflow_match", 0, 0);
    cmd(4'd8, "overflow_cmd_match", 0, 0);
    digit(4'd5); digits4(16'h6601);
    expect_out("overflow_keeps_newest", 0, 1);
    tick();

    // Command key with no mode active changes nothing.
    CheckPC = 1'b0;
    cmd(4'd9, "idle_cmd_match", 0, 0);
    expect_out("idle_count", 3, 0);
    expect_out("idle_locked", 2, 0);
    tick();

    // Lock again so reset has state to clear.
    LOCKING = 1'b1;
    digits4(16'h1111);
    cmd(4'd9, "relock_match", 0, 1);
    LOCKING = 1'b0;
    toggle();
    expect_out("relocked", 2, 1);
    tick();

    // 6. Reset mid-entry; a pulse between edges is ignored.
    CheckPC = 1'b1;
    digit(4'd1); digit(4'd2);
    #1 resetN = 1'b0;
    #1 resetN = 1'b1;
    expect_out("glitch_count_kept", 3, 2);
    expect_out("glitch_locked_kept", 2, 1);
    tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    expect_out("reset_mid_count", 3, 0);
    expect_out("reset_mid_locked", 2, 0);
    digits4(16'h1234);
    cmd(4'd8, "reset_pc_restored", 0, 1);
    CheckPC = 1'b0;

    repeat (3) tick();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
